// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, memory access row codes, word and memory sizes.
package cpu_pkg;

  localparam int WORD_W   = 32;
  localparam int MEM_SIZE = 4096;

  typedef enum logic [3:0] {
    ALU_LW   = 4'b0000,
    ALU_SW   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_BEQ  = 4'b0110,
    ALU_JMP  = 4'b0111,
    ALU_ADDI = 4'b1000,
    ALU_MULI = 4'b1001
  } opcode_e;

  typedef enum logic [1:0] {
    ROW_NOP = 2'b00,
    ROW_RD  = 2'b01,
    ROW_WR  = 2'b10
  } row_e;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge word memory port between the MEM stage and data memory.
interface mem_stage_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              ack;
  logic [WORD_W-1:0] rdata;

  modport master (output req, output we, output addr, output wdata,
                  input  ack, input  rdata);

  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output ack, output rdata);

endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory access; expired flags the last allowed cycle.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes non-memory ops through in one cycle and performs
// word loads/stores over a req/ack port, abandoning an access after a bounded wait.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [WORD_W-1:0] data1_i,
  input  logic [WORD_W-1:0] data2_i,
  input  logic [WORD_W-1:0] IR_i,
  input  logic [1:0]        row_i,
  input  logic              control_i,
  mem_stage_if.master       mem,
  output logic [WORD_W-1:0] result_o,
  output logic [WORD_W-1:0] IR_o,
  output logic              control_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic              err_o
);

  mem_state_e        state;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] ir_q;
  logic              ctrl_q;
  logic              timer_clear;
  logic              timer_enable;
  logic              timer_expired;

  assign stall_o      = (state == MS_WAIT);
  assign timer_clear  = (state == MS_IDLE);
  assign timer_enable = (state == MS_WAIT) && !mem.ack;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // The full byte address is kept so a store can report it as its write-back value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= MS_IDLE;
      addr_q    <= '0;
      ir_q      <= '0;
      ctrl_q    <= 1'b0;
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      result_o  <= '0;
      IR_o      <= '0;
      control_o <= 1'b0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (row_i == ROW_RD || row_i == ROW_WR) begin
            addr_q    <= data1_i;
            ir_q      <= IR_i;
            ctrl_q    <= control_i;
            mem.req   <= 1'b1;
            mem.we    <= (row_i == ROW_WR);
            mem.addr  <= data1_i[ADDR_W+1:2];
            mem.wdata <= data2_i;
            valid_o   <= 1'b0;
            state     <= MS_WAIT;
          end else begin
            result_o  <= data1_i;
            IR_o      <= IR_i;
            control_o <= control_i;
            valid_o   <= 1'b1;
          end
        end
        MS_WAIT: begin
          // An ack arriving on the final allowed cycle still completes normally.
          if (mem.ack) begin
            result_o  <= mem.we ? addr_q : mem.rdata;
            IR_o      <= ir_q;
            control_o <= ctrl_q;
            valid_o   <= 1'b1;
            mem.req   <= 1'b0;
            state     <= MS_IDLE;
          end else if (timer_expired) begin
            result_o  <= '0;
            IR_o      <= ir_q;
            control_o <= ctrl_q;
            valid_o   <= 1'b1;
            err_o     <= 1'b1;
            mem.req   <= 1'b0;
            state     <= MS_IDLE;
          end else begin
            valid_o   <= 1'b0;
          end
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage with a behavioural memory model.
module tb_mem_stage;
  import cpu_pkg::*;

  localparam int ADDR_W = 10;
  localparam int TO     = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk_i;
  logic        rst_n_i;
  logic [31:0] data1_i, data2_i, IR_i;
  logic [1:0]  row_i;
  logic        control_i;
  logic [31:0] result_o, IR_o;
  logic        control_o, valid_o, stall_o, err_o;

  mem_stage_if #(.ADDR_W(ADDR_W)) mem_bus ();

  mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .IR_i      (IR_i),
    .row_i     (row_i),
    .control_i (control_i),
    .mem       (mem_bus.master),
    .result_o  (result_o),
    .IR_o      (IR_o),
    .control_o (control_o),
    .valid_o   (valid_o),
    .stall_o   (stall_o),
    .err_o     (err_o)
  );

  int          checks = 0;
  int          errors = 0;
  logic        exp_err = 1'b0;
  logic [31:0] mem_model [DEPTH];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_nop();
    row_i = ROW_NOP;
    mem_bus.ack = 1'b0;
  endtask

  // Issues one load/store and follows it to completion; ack_after = 0 means never acked.
  task automatic run_mem_op(input logic [1:0] row, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] ir, input logic ctrl, input int ack_after);
    int          idx;
    logic [31:0] exp_res;
    logic        is_wr;
    idx   = (a / 4) % DEPTH;
    is_wr = (row == ROW_WR);
    row_i = row; data1_i = a; data2_i = d; IR_i = ir; control_i = ctrl;
    mem_bus.ack = 1'b0;
    tick();
    checks++;
    if ({mem_bus.req, stall_o, valid_o, mem_bus.we} !== {1'b1, 1'b1, 1'b0, is_wr}) begin
      errors++;
      $display("[TB] FAIL accept_flags req/stall/valid/we got %b exp %b",
               {mem_bus.req, stall_o, valid_o, mem_bus.we}, {1'b1, 1'b1, 1'b0, is_wr});
    end
    checks++;
    if (mem_bus.addr !== ADDR_W'(idx) || (is_wr && mem_bus.wdata !== d)) begin
      errors++;
      $display("[TB] FAIL accept_bus addr got %0d exp %0d wdata got %h exp %h",
               mem_bus.addr, idx, mem_bus.wdata, d);
    end
    for (int j = 1; j <= TO; j++) begin
      row_i = 2'($urandom); data1_i = $urandom; data2_i = $urandom;
      IR_i = $urandom; control_i = 1'($urandom);
      mem_bus.ack   = (j == ack_after);
      mem_bus.rdata = (j == ack_after && !is_wr) ? mem_model[idx] : $urandom;
      tick();
      if (j == ack_after || j == TO) begin
        if (j == ack_after) begin
          exp_res = is_wr ? a : mem_model[idx];
          if (is_wr) mem_model[idx] = d;
        end else begin
          exp_res = 32'h0;
          exp_err = 1'b1;
        end
        checks++;
        if (result_o !== exp_res) begin
          errors++;
          $display("[TB] FAIL done_result got %h exp %h", result_o, exp_res);
        end
        checks++;
        if ({IR_o, control_o, valid_o, stall_o, mem_bus.req, err_o} !== {ir, ctrl, 1'b1, 1'b0, 1'b0, exp_err}) begin
          errors++;
          $display("[TB] FAIL done_status IR %h ctrl %b valid %b stall %b req %b err %b exp IR %h ctrl %b err %b",
                   IR_o, control_o, valid_o, stall_o, mem_bus.req, err_o, ir, ctrl, exp_err);
        end
        break;
      end else begin
        checks++;
        if ({stall_o, valid_o, mem_bus.req, mem_bus.we, mem_bus.addr} !== {1'b1, 1'b0, 1'b1, is_wr, ADDR_W'(idx)}) begin
          errors++;
          $display("[TB] FAIL wait_hold cycle %0d stall %b valid %b req %b we %b addr %0d", j,
                   stall_o, valid_o, mem_bus.req, mem_bus.we, mem_bus.addr);
        end
      end
    end
    drive_nop();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    data1_i = '0; data2_i = '0; IR_i = '0; row_i = ROW_NOP; control_i = 1'b0;
    mem_bus.ack = 1'b0; mem_bus.rdata = '0;
    #1;
    checks++;
    if ({mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bus req %b we %b addr %h wdata %h exp all 0",
               mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata);
    end
    checks++;
    if ({result_o, IR_o, control_o, valid_o, stall_o, err_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out result %h IR %h ctrl %b valid %b stall %b err %b exp all 0",
               result_o, IR_o, control_o, valid_o, stall_o, err_o);
    end
    tick(); tick();
    rst_n_i = 1'b1;
    exp_err = 1'b0;
  endtask

  task automatic test_nop();
    logic [31:0] d, ir;
    logic        c;
    row_i = ROW_NOP; data1_i = 32'h1234; IR_i = 32'h3000_0000; control_i = 1'b0;
    tick();
    checks++;
    if ({result_o, IR_o, valid_o, stall_o} !== {32'h1234, 32'h3000_0000, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL nop_basic result %h IR %h valid %b stall %b", result_o, IR_o, valid_o, stall_o);
    end
    for (int i = 0; i < 12; i++) begin
      d = $urandom; ir = $urandom; c = 1'($urandom);
      row_i = (i % 2 == 0) ? ROW_NOP : 2'b11;
      data1_i = d; IR_i = ir; control_i = c; data2_i = $urandom;
      mem_bus.ack = 1'($urandom); mem_bus.rdata = $urandom;
      tick();
      checks++;
      if ({result_o, IR_o, control_o, valid_o, stall_o, mem_bus.req, err_o} !== {d, ir, c, 1'b1, 1'b0, 1'b0, exp_err}) begin
        errors++;
        $display("[TB] FAIL nop_stream %0d result %h IR %h ctrl %b valid %b stall %b req %b exp %h %h %b",
                 i, result_o, IR_o, control_o, valid_o, stall_o, mem_bus.req, d, ir, c);
      end
    end
    drive_nop();
  endtask

  task automatic test_load();
    mem_model[4] = 32'hDEAD_BEEF;
    run_mem_op(ROW_RD, 32'h0000_0010, $urandom, {ALU_LW, 28'h0}, 1'b0, 3);
  endtask

  task automatic test_store();
    run_mem_op(ROW_WR, 32'h20, 32'h55, {ALU_SW, 28'h0}, 1'b1, 1);
    run_mem_op(ROW_RD, 32'hFFFF_F023, $urandom, {ALU_LW, 28'h1}, 1'b0, 2);
  endtask

  task automatic test_ack_at_timeout();
    run_mem_op(ROW_RD, $urandom, $urandom, {ALU_LW, 28'h2}, 1'b1, TO);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      run_mem_op(($urandom % 2) ? ROW_WR : ROW_RD, $urandom % 64, $urandom, $urandom,
                 1'($urandom), $urandom_range(1, 6));
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    run_mem_op(ROW_RD, 32'h40, $urandom, {ALU_LW, 28'h3}, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      row_i = ROW_NOP; data1_i = d; IR_i = 32'h2000_0000;
      tick();
      checks++;
      if ({result_o, valid_o, err_o} !== {d, 1'b1, 1'b1}) begin
        errors++;
        $display("[TB] FAIL post_timeout_nop result %h valid %b err %b exp %h 1 1", result_o, valid_o, err_o, d);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    row_i = ROW_RD; data1_i = 32'h80; IR_i = {ALU_LW, 28'h4}; mem_bus.ack = 1'b0;
    tick();
    drive_nop();
    tick(); tick(); tick();
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({mem_bus.req, stall_o, valid_o, err_o} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_wait req %b stall %b valid %b err %b exp 0000",
               mem_bus.req, stall_o, valid_o, err_o);
    end
    tick();
    checks++;
    if ({mem_bus.req, stall_o, valid_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_hold req %b stall %b valid %b exp 000", mem_bus.req, stall_o, valid_o);
    end
    rst_n_i = 1'b1;
    exp_err = 1'b0;
    tick();
    run_mem_op(ROW_RD, 32'h0000_0010, $urandom, {ALU_LW, 28'h5}, 1'b0, 2);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_model[i] = $urandom;
    test_reset();
    test_nop();
    test_load();
    test_store();
    test_ack_at_timeout();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
